upload_framer: RTL
==================

# upload_framer

Packet framer and output scheduler for the upload path, placed between `upload_arbiter`'s merged upload stream and the byte-wide host transmit link. It collects payload bytes from one source into a local buffer and decides when that packet is complete. It then emits a framed packet: start-of-frame, source, length, payload and an optional checksum. While a frame is being sent it holds off the upstream arbiter, so frames never interleave.

## Interface
- `MAX_PAYLOAD`, 64: payload buffer depth in bytes, and the maximum payload length per frame.
- `FLUSH_TIMEOUT`, 256: idle cycles with a partially filled buffer before the buffer is force-closed.
- `clk`  in  1  clock.
- `rst_n`  in  1  asynchronous, active-low reset.
- `in_req`  in  1  packet-in-progress flag from the arbiter; 0 marks a packet boundary.
- `in_data`  in  8  payload byte.
- `in_source`  in  8  source ID of the byte.
- `in_valid`  in  1  byte valid.
- `in_ready`  out  1  byte accepted when `in_valid && in_ready`.
- `out_data`  out  8  framed byte to the transmit link.
- `out_valid`  out  1  `out_data` valid.
- `out_last`  out  1  marks the final byte of a frame.
- `out_ready`  in  1  link accepts the byte.
- `busy`  out  1  high when in the HDR, PAYLOAD or CKSUM state.

## Operation
- **States:** COLLECT → HDR → PAYLOAD → CKSUM (CKSUM only when the macro is defined) → COLLECT.
- **COLLECT, `in_ready`:** combinational; equal to `(state==COLLECT) && (cnt<MAX_PAYLOAD) && !(cnt>0 && in_source!=buf_src)`.
- **COLLECT, accepted byte:** written to `buf[cnt]`, then `cnt++`. The first accepted byte latches `buf_src`.
- **Close conditions:** evaluated every cycle while in COLLECT with `cnt>0`. The first one to hit moves the block to HDR on the next edge:
  - (a) an accepted byte makes `cnt==MAX_PAYLOAD`.
  - (b) `in_req==0` in a cycle with no handshake.
  - (c) `in_valid && in_source!=buf_src`. The offending byte is not accepted; it is taken after the frame completes.
  - (d) the idle counter reaches `FLUSH_TIMEOUT`. It counts consecutive cycles with no handshake and resets on every handshake.
- **Empty buffer:** with `cnt==0` no close occurs, and `in_req` toggles are ignored.
- **HDR:** emits 5 bytes in order: 0xAA, 0x44, `buf_src`, `len[15:8]`, `len[7:0]`. `len` is `cnt` zero-extended to 16 bits.
- **PAYLOAD:** emits `buf[0]` through `buf[len-1]`.
- **CKSUM:** emits the 8-bit wrapping sum of `buf_src`, both length bytes and all payload bytes.
- **Sequencing:** every output byte advances only on `out_valid && out_ready`. After the last byte's handshake the block returns to COLLECT with `cnt=0` and the idle counter at 0.
- **Width rules:**
  - `cnt` and the read index are `$clog2(MAX_PAYLOAD+1)` bits wide.
  - The idle counter is `$clog2(FLUSH_TIMEOUT+1)` bits wide and saturates.
  - The checksum accumulates during the payload phase; it is not precomputed.
- **Reset:** all state clears asynchronously. A partially collected or partially emitted frame is discarded. Nothing resumes after reset.

## Timing
- **Reset values:** `out_valid`, `out_last` and `busy` are 0; `out_data` is 0x00. `in_ready` follows its equation, so it is 1 after reset.
- **Start of frame:** the close is detected in cycle N; `out_valid` rises registered in N+1 with `out_data`=0xAA.
- **Throughput:** with `out_ready` held at 1, one byte per cycle with no bubbles between header, payload and checksum. A frame therefore takes `5+len(+1)` cycles.
- **Backpressure:** while `out_valid && !out_ready`, `out_data` and `out_last` are held stable.
- **`out_last`:** asserted together with the checksum byte, or with the last payload byte when the macro is not defined.
- **Return to COLLECT:** `in_ready` may assert in the cycle after the final output handshake.
- **Buffer read:** the buffer is read synchronously, with a 1-cycle latency. The read for payload byte 0 is issued during header byte 4, so the payload phase has no stall.

## Configuration
- The macro is `UPLOAD_FRAMER_CHECKSUM_EN`.
- **Defined:** the CKSUM state exists and frames are `6+len` bytes.
- **Undefined:** the CKSUM state and the accumulator are removed, frames are `5+len` bytes, and `out_last` falls on the last payload byte.

## Structure
- Shared package `upload_pkg` holds:
  - SOF constants `UPLOAD_SOF0`=0xAA and `UPLOAD_SOF1`=0x44.
  - Header length `UPLOAD_HDR_LEN`=5.
  - The state enum `upload_framer_state_t`.
- One sub-module, `upload_frame_buf`: a simple dual-port RAM, 8 bits × `MAX_PAYLOAD`, with a registered read port. It maps onto vendor BSRAM.

## Test plan
- **Basic frame:** src 0x01 sends 0x11, 0x22, 0x33 with req=1, then req=0 → AA 44 01 00 03 11 22 33 6A. `out_last` is high on 0x6A.
- **Length split:** with `MAX_PAYLOAD`=4, six bytes 0x00–0x05 from src 0x02 with continuous req → frame with len 4 (00–03), then frame with len 2 (04, 05).
- **Source change:** two bytes from src 0x02, then `in_valid` with src 0x03 → `in_ready` is 0 for the 0x03 byte. A len-2 frame for 0x02 is emitted, then the 0x03 byte is accepted in the cycle after `out_last`.
- **Backpressure:** `out_ready` toggles every cycle during a 3-byte frame → no byte is lost or duplicated, `out_data` is stable while stalled, and the frame takes 2× as many cycles.
- **Timeout:** with `FLUSH_TIMEOUT`=16, one byte 0x5A from src 0x04 with req held at 1, then silence → `out_valid` rises 17 cycles after the handshake, and the frame has len 1.
- **Reset mid-frame:** `rst_n` is pulsed during payload byte 1 of a 3-byte frame → `out_valid` is 0 immediately. After release `cnt` is 0 and no remnant bytes are emitted.

Source files
------------

// File: rtl/upload_pkg.sv
// upload_pkg: shared constants, state type and header helper for the upload path.
// The checksum trailer state only exists when UPLOAD_FRAMER_CHECKSUM_EN is defined.
package upload_pkg;

    localparam logic [7:0] UPLOAD_SOF0    = 8'hAA;
    localparam logic [7:0] UPLOAD_SOF1    = 8'h44;
    localparam int         UPLOAD_HDR_LEN = 5;

    typedef enum logic [1:0] {
        ST_COLLECT = 2'd0,
        ST_HDR     = 2'd1,
        ST_PAYLOAD = 2'd2
`ifdef UPLOAD_FRAMER_CHECKSUM_EN
        ,
        ST_CKSUM   = 2'd3
`endif
    } upload_framer_state_t;

    // Header byte at position idx: SOF0, SOF1, source, length high, length low.
    function automatic logic [7:0] upload_hdr_byte(
        input logic [2:0]  idx,
        input logic [7:0]  src,
        input logic [15:0] len
    );
        logic [7:0] b;
        case (idx)
            3'd0:    b = UPLOAD_SOF0;
            3'd1:    b = UPLOAD_SOF1;
            3'd2:    b = src;
            3'd3:    b = len[15:8];
            default: b = len[7:0];
        endcase
        return b;
    endfunction

endpackage

// File: rtl/upload_frame_buf.sv
// upload_frame_buf: simple dual-port payload RAM, 8 bits wide, registered read port.
// No reset on the array or read register so it maps onto block RAM.
module upload_frame_buf #(
    parameter int DEPTH = 64,
    parameter int AW    = 6
) (
    input  logic          clk,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [7:0]    wr_data,
    input  logic [AW-1:0] rd_addr,
    output logic [7:0]    rd_data
);

    logic [7:0] mem [DEPTH];

    // One write port and one always-enabled synchronous read port.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
        rd_data <= mem[rd_addr];
    end

endmodule

// File: rtl/upload_framer.sv
// upload_framer: collects one source's payload bytes, then emits
// SOF0 SOF1 src len_hi len_lo payload [checksum] to the byte-wide transmit link.
// Define UPLOAD_FRAMER_CHECKSUM_EN to append the 8-bit wrapping checksum trailer.
module upload_framer
    import upload_pkg::*;
#(
    parameter int MAX_PAYLOAD   = 64,
    parameter int FLUSH_TIMEOUT = 256
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       in_req,
    input  logic [7:0] in_data,
    input  logic [7:0] in_source,
    input  logic       in_valid,
    output logic       in_ready,
    output logic [7:0] out_data,
    output logic       out_valid,
    output logic       out_last,
    input  logic       out_ready,
    output logic       busy
);

    localparam int CW = $clog2(MAX_PAYLOAD + 1);
    localparam int AW = (MAX_PAYLOAD > 1) ? $clog2(MAX_PAYLOAD) : 1;
    localparam int IW = $clog2(FLUSH_TIMEOUT + 1);

    localparam logic [CW-1:0] CNT_MAX   = CW'(MAX_PAYLOAD);
    localparam logic [CW-1:0] CNT_LAST  = CW'(MAX_PAYLOAD - 1);
    localparam logic [IW-1:0] IDLE_MAX  = IW'(FLUSH_TIMEOUT);
    localparam logic [IW-1:0] IDLE_LAST = IW'(FLUSH_TIMEOUT - 1);
    localparam logic [2:0]    HDR_LAST  = 3'(UPLOAD_HDR_LEN - 1);

    upload_framer_state_t state;
    upload_framer_state_t state_next;

    logic [CW-1:0] cnt;
    logic [7:0]    buf_src;
    logic [IW-1:0] idle;
    logic [2:0]    hdr_idx;
    logic [CW-1:0] rd_idx;
    logic [CW-1:0] rd_next;
    logic [7:0]    rd_data;
    logic [15:0]   len16;

    logic in_hs;
    logic out_hs;
    logic close_now;
    logic last_payload;
    logic frame_done;

`ifdef UPLOAD_FRAMER_CHECKSUM_EN
    logic [7:0] cksum;
`endif

    // A byte is refused while emitting, when the buffer is full, or when it
    // belongs to a different source than the packet already buffered.
    assign in_ready = (state == ST_COLLECT) && (cnt < CNT_MAX)
                      && !((cnt != '0) && (in_source != buf_src));

    assign in_hs        = in_valid && in_ready;
    assign out_hs       = (state != ST_COLLECT) && out_ready;
    assign len16        = 16'(cnt);
    assign last_payload = (rd_idx == (cnt - CW'(1)));
    assign frame_done   = (state != ST_COLLECT) && (state_next == ST_COLLECT);

    // Buffer is closed on fill-up, packet boundary, source change or idle flush.
    assign close_now = (state == ST_COLLECT) && (cnt != '0) && (
                           (in_hs && (cnt == CNT_LAST))
                        || (!in_hs && !in_req)
                        || (in_valid && (in_source != buf_src))
                        || (!in_hs && (idle >= IDLE_LAST)));

    upload_frame_buf #(
        .DEPTH (MAX_PAYLOAD),
        .AW    (AW)
    ) u_buf (
        .clk     (clk),
        .wr_en   (in_hs),
        .wr_addr (cnt[AW-1:0]),
        .wr_data (in_data),
        .rd_addr (rd_next[AW-1:0]),
        .rd_data (rd_data)
    );

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_COLLECT;
        end else begin
            state <= state_next;
        end
    end

    // Next-state: each emitting state advances only on an output handshake.
    always_comb begin
        state_next = state;
        case (state)
            ST_COLLECT: begin
                if (close_now) begin
                    state_next = ST_HDR;
                end
            end
            ST_HDR: begin
                if (out_hs && (hdr_idx == HDR_LAST)) begin
                    state_next = ST_PAYLOAD;
                end
            end
            ST_PAYLOAD: begin
                if (out_hs && last_payload) begin
`ifdef UPLOAD_FRAMER_CHECKSUM_EN
                    state_next = ST_CKSUM;
`else
                    state_next = ST_COLLECT;
`endif
                end
            end
`ifdef UPLOAD_FRAMER_CHECKSUM_EN
            ST_CKSUM: begin
                if (out_hs) begin
                    state_next = ST_COLLECT;
                end
            end
`endif
            default: state_next = ST_COLLECT;
        endcase
    end

    // Outputs and RAM read address; the read for the next payload byte is
    // issued on the current handshake so payload bytes flow without bubbles.
    always_comb begin
        out_valid = 1'b0;
        out_last  = 1'b0;
        out_data  = 8'h00;
        busy      = 1'b0;
        rd_next   = '0;
        case (state)
            ST_HDR: begin
                out_valid = 1'b1;
                busy      = 1'b1;
                out_data  = upload_hdr_byte(hdr_idx, buf_src, len16);
                rd_next   = '0;
            end
            ST_PAYLOAD: begin
                out_valid = 1'b1;
                busy      = 1'b1;
                out_data  = rd_data;
`ifndef UPLOAD_FRAMER_CHECKSUM_EN
                out_last  = last_payload;
`endif
                if (out_hs && !last_payload) begin
                    rd_next = rd_idx + CW'(1);
                end else begin
                    rd_next = rd_idx;
                end
            end
`ifdef UPLOAD_FRAMER_CHECKSUM_EN
            ST_CKSUM: begin
                out_valid = 1'b1;
                busy      = 1'b1;
                out_data  = cksum;
                out_last  = 1'b1;
            end
`endif
            default: begin
                out_valid = 1'b0;
            end
        endcase
    end

    // Fill count and source latch; count clears once the frame has gone out.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt     <= '0;
            buf_src <= 8'h00;
        end else if (in_hs) begin
            cnt <= cnt + CW'(1);
            if (cnt == '0) begin
                buf_src <= in_source;
            end
        end else if (frame_done) begin
            cnt <= '0;
        end
    end

    // Saturating count of consecutive cycles without an input handshake.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idle <= '0;
        end else if (in_hs || (state != ST_COLLECT)) begin
            idle <= '0;
        end else if (idle != IDLE_MAX) begin
            idle <= idle + IW'(1);
        end
    end

    // Header position and payload read index for the frame being emitted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hdr_idx <= '0;
            rd_idx  <= '0;
        end else if (close_now) begin
            hdr_idx <= '0;
            rd_idx  <= '0;
        end else begin
            if ((state == ST_HDR) && out_hs) begin
                hdr_idx <= hdr_idx + 3'd1;
            end
            if (state == ST_PAYLOAD) begin
                rd_idx <= rd_next;
            end
        end
    end

`ifdef UPLOAD_FRAMER_CHECKSUM_EN
    // Running sum of source, length bytes and payload as each is sent.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cksum <= 8'h00;
        end else if (close_now) begin
            cksum <= 8'h00;
        end else if (out_hs && (((state == ST_HDR) && (hdr_idx >= 3'd2))
                                || (state == ST_PAYLOAD))) begin
            cksum <= cksum + out_data;
        end
    end
`endif

endmodule
